fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4: queue entries and maximum outstanding-plus-buffered fetches (power of two, 2..16).
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port imem_req, output, 1 bit: fetch request valid.
REQ-006 The block SHALL have port imem_addr, output, 32 bits: fetch word address, low 2 bits always 0.
REQ-007 The block SHALL have port imem_gnt, input, 1 bit: request accepted this cycle when imem_req is also high.
REQ-008 The block SHALL have port imem_rvalid, input, 1 bit: response data valid; responses return in request order, latency 1 or more cycles.
REQ-009 The block SHALL have port imem_rdata, input, 32 bits: fetched instruction word.
REQ-010 The block SHALL have port out_valid, output, 1 bit: queue head valid toward the decode/execute stage.
REQ-011 The block SHALL have port out_ready, input, 1 bit: consumer accepts the head.
REQ-012 The block SHALL have port out_instr, output, 32 bits: head instruction.
REQ-013 The block SHALL have port out_pc, output, 32 bits: address of the head instruction.
REQ-014 The block SHALL have port redirect, input, 1 bit: branch/jump taken; flush and refetch.
REQ-015 The block SHALL have port redirect_pc, input, 32 bits: new fetch address; bits [1:0] are ignored and treated as 0.

Function
REQ-016 fetch_pc register SHALL drive imem_addr and advance by 4 only on an imem_req && imem_gnt cycle.
REQ-017 imem_req SHALL be high iff (outstanding + occupancy) < DEPTH, redirect is low, and the block is not in reset.
REQ-018 While imem_req is high without imem_gnt, imem_addr SHALL hold stable.
REQ-019 outstanding SHALL increment on grant and decrement on each imem_rvalid; grant and rvalid in the same cycle SHALL leave it unchanged.
REQ-020 Each non-discarded imem_rvalid SHALL push {pc, imem_rdata} into the queue; the pushed pc is the address of the matching grant (in order).
REQ-021 The credit rule in REQ-017 SHALL guarantee that the queue never overflows; push and pop in the same cycle SHALL be legal at any occupancy.
REQ-022 out_valid SHALL equal queue-not-empty; out_instr/out_pc SHALL come from the head and remain stable while out_valid && !out_ready.
REQ-023 A pop SHALL occur on out_valid && out_ready; first data SHALL appear on out_valid the cycle after its imem_rvalid (1-cycle latency).
REQ-024 On redirect: queue SHALL be flushed, fetch_pc SHALL load {redirect_pc[31:2],2'b00}, and discard count SHALL load the outstanding count after this cycle's rvalid, if any.
REQ-025 While discard count > 0, each imem_rvalid SHALL decrement discard count and outstanding and SHALL NOT push.
REQ-026 An imem_rvalid in the redirect cycle SHALL be dropped; a pop handshake in the redirect cycle SHALL count as consumed.
REQ-027 New requests SHALL resume the cycle after redirect, with the credit rule still applied to the remaining outstanding count.
REQ-028 fetch_pc SHALL wrap modulo 2^32 without error.

Reset
REQ-029 While rst is low: imem_req=0, out_valid=0, fetch_pc=RESET_PC, queue empty, outstanding=0, discard count=0.
REQ-030 Assertion mid-operation SHALL take effect immediately (asynchronously); in-flight responses after release are undefined and shall not be driven by the environment.
REQ-031 The first imem_req SHALL be asserted in the first cycle after rst deasserts, with address RESET_PC.

Structure
REQ-032 Package fetch_pkg SHALL hold the XLEN=32 constant, the default DEPTH, RESET_PC, and the queue-entry struct {pc, instr}.
REQ-033 The storage SHALL be one sub-module, fetch_fifo (synchronous, 64-bit entries, DEPTH deep, flush input); the control and counters SHALL live in fetch_queue.

Verification
REQ-034 Reset, memory latency 1, out_ready=1 -> out_pc 0,4,8,12..., out_instr matches memory, one instruction per cycle in steady state.
REQ-035 out_ready=0 -> exactly 4 grants, then imem_req=0; release out_ready -> pcs 0,4,8,12 in order with no loss or duplication.
REQ-036 Redirect to 0x100 with 2 outstanding and 1 queued -> both late responses dropped; next out_pc=0x100 with the correct instruction.
REQ-037 imem_gnt held low for 5 cycles -> imem_req high and imem_addr stable throughout; fetch proceeds after grant.
REQ-038 rst low with 3 queued entries -> out_valid=0 and imem_req=0 the same cycle; after release, fetch restarts at RESET_PC.
REQ-039 redirect_pc=0x103 coincident with rvalid and a pop -> fetch at 0x100; rvalid dropped; popped entry consumed once.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch queue.
package fetch_pkg;

   localparam int               XLEN             = 32;
   localparam int               DEPTH_DEFAULT    = 4;
   localparam logic [XLEN-1:0]  RESET_PC_DEFAULT = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return addr & {{(XLEN-2){1'b1}}, 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched {pc, instr} entries with a single-cycle flush.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  fetch_entry_t           push_data,
   input  logic                   pop,
   input  logic                   flush,
   output fetch_entry_t           head,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = $clog2(DEPTH);

   fetch_entry_t     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;

   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: the storage array has no reset; count_q alone defines which entries are live.
   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wr_ptr_q] <= push_data;
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: credit-limited requests, in-order response capture, redirect flush.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int              DEPTH    = DEPTH_DEFAULT,
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_instr,
   output logic [XLEN-1:0] out_pc,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc
);

   localparam int               CNT_W        = $clog2(DEPTH) + 1;
   localparam logic [CNT_W:0]   CREDIT_LIMIT = (CNT_W+1)'(DEPTH);

   logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
   logic [CNT_W-1:0] outstanding_q, outstanding_d;
   logic [CNT_W-1:0] discard_q, discard_d;
   logic [CNT_W-1:0] fifo_count;
   logic [CNT_W:0]   credit_used;
   logic             grant, push, pop;
   fetch_entry_t     push_entry, head_entry;

   // Outstanding requests plus buffered entries never exceed DEPTH, so a push always has room.
   assign credit_used = {1'b0, outstanding_q} + {1'b0, fifo_count};
   assign imem_req    = rst && !redirect && (credit_used < CREDIT_LIMIT);
   assign grant       = imem_req && imem_gnt;
   assign out_valid   = (fifo_count != '0);
   assign pop         = out_valid && out_ready;
   assign push        = imem_rvalid && !redirect && (discard_q == '0);
   assign push_entry  = '{pc: resp_pc_q, instr: imem_rdata};

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      resp_pc_d     = resp_pc_q;
      discard_d     = discard_q;
      outstanding_d = outstanding_q + CNT_W'(grant) - CNT_W'(imem_rvalid);
      if (redirect) begin
         // Everything still in flight belongs to the abandoned path.
         fetch_pc_d = word_align(redirect_pc);
         resp_pc_d  = word_align(redirect_pc);
         discard_d  = outstanding_q - CNT_W'(imem_rvalid);
      end else begin
         if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
         if (push)  resp_pc_d  = resp_pc_q + 32'd4;
         if (imem_rvalid && discard_q != '0) discard_d = discard_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc_q    <= word_align(RESET_PC);
         resp_pc_q     <= word_align(RESET_PC);
         outstanding_q <= '0;
         discard_q     <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
      end
   end

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .flush     (redirect),
      .head      (head_entry),
      .count     (fifo_count)
   );

   assign imem_addr = fetch_pc_q;
   assign out_pc    = head_entry.pc;
   assign out_instr = head_entry.instr;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench: randomized memory/consumer against a stream-level reference model.
module tb_fetch_queue;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk, rst;
   logic        imem_req, imem_gnt, imem_rvalid;
   logic [31:0] imem_addr, imem_rdata;
   logic        out_valid, out_ready;
   logic [31:0] out_instr, out_pc;
   logic        redirect;
   logic [31:0] redirect_pc;

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_instr   (out_instr),
      .out_pc      (out_pc),
      .redirect    (redirect),
      .redirect_pc (redirect_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          epoch;
      int          cyc;
   } pend_t;

   // Reference model: memory requests in flight, entries the queue should hold,
   // the next address to be fetched and the next pc the consumer should see.
   pend_t       pend[$];
   int          occ, epoch, cyc;
   logic [31:0] fetch_exp, exp_pc;

   logic        obs_req, obs_valid, obs_grant, obs_pop;
   logic [31:0] obs_addr, obs_pc, obs_instr;
   logic        exp_req, exp_valid;
   logic [31:0] exp_addr, exp_head_pc, exp_head_instr;

   int n_checks = 0;
   int n_pass   = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_F00D;
   endfunction

   task automatic model_reset();
      pend.delete();
      occ       = 0;
      epoch     = epoch + 1;
      fetch_exp = RESET_PC;
      exp_pc    = RESET_PC;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      out_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   // One clock: drive inputs at the falling edge, sample, then advance the model for the rising edge.
   // rv_mode: 0 = memory silent, 1 = respond whenever possible, 2 = respond at random.
   task automatic cycle(input logic gnt, input logic ready, input logic redir,
                        input logic [31:0] rpc, input int rv_mode);
      pend_t e;
      logic  do_rv, deliver;
      @(negedge clk);
      do_rv = 1'b0;
      if (pend.size() > 0 && pend[0].cyc < cyc) begin
         if (rv_mode == 1)      do_rv = 1'b1;
         else if (rv_mode == 2) do_rv = ($urandom_range(0, 2) != 0);
      end
      imem_gnt    = gnt;
      out_ready   = ready;
      redirect    = redir;
      redirect_pc = rpc;
      imem_rvalid = do_rv;
      imem_rdata  = do_rv ? mem_word(pend[0].addr) : $urandom;
      #1;
      obs_req   = imem_req;   obs_addr  = imem_addr;
      obs_valid = out_valid;  obs_pc    = out_pc;   obs_instr = out_instr;
      exp_req        = !redir && ((pend.size() + occ) < DEPTH);
      exp_addr       = fetch_exp;
      exp_valid      = (occ != 0);
      exp_head_pc    = exp_pc;
      exp_head_instr = mem_word(exp_pc);
      obs_grant = imem_req && gnt;
      obs_pop   = out_valid && ready;
      deliver = 1'b0;
      if (do_rv) begin
         e = pend.pop_front();
         deliver = !redir && (e.epoch == epoch);
      end
      if (obs_pop && occ > 0) begin
         occ    = occ - 1;
         exp_pc = exp_pc + 32'd4;
      end
      if (deliver) occ = occ + 1;
      if (obs_grant) begin
         pend.push_back('{addr: fetch_exp, epoch: epoch, cyc: cyc});
         fetch_exp = fetch_exp + 32'd4;
      end
      if (redir) begin
         occ       = 0;
         epoch     = epoch + 1;
         fetch_exp = rpc & ~32'h3;
         exp_pc    = rpc & ~32'h3;
      end
      cyc = cyc + 1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      #1;
      n_checks++;
      if (imem_req !== 1'b0) $display("FAIL reset_req got=%b exp=0", imem_req); else n_pass++;
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", out_valid); else n_pass++;
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_checks++;
      if (imem_req !== 1'b1) $display("FAIL release_req got=%b exp=1", imem_req); else n_pass++;
      n_checks++;
      if (imem_addr !== RESET_PC) $display("FAIL release_addr got=%h exp=%h", imem_addr, RESET_PC); else n_pass++;
   endtask

   task automatic test_stream_lat1();
      int pops;
      pops = 0;
      do_reset();
      for (int i = 0; i < 30; i++) begin
         cycle(1'b1, 1'b1, 1'b0, '0, 1);
         n_checks++;
         if (obs_req !== exp_req) $display("FAIL stream_req i=%0d got=%b exp=%b", i, obs_req, exp_req); else n_pass++;
         if (exp_req) begin
            n_checks++;
            if (obs_addr !== exp_addr) $display("FAIL stream_addr i=%0d got=%h exp=%h", i, obs_addr, exp_addr); else n_pass++;
         end
         if (exp_valid) begin
            n_checks++;
            if (obs_pc !== exp_head_pc) $display("FAIL stream_pc i=%0d got=%h exp=%h", i, obs_pc, exp_head_pc); else n_pass++;
            n_checks++;
            if (obs_instr !== exp_head_instr) $display("FAIL stream_instr i=%0d got=%h exp=%h", i, obs_instr, exp_head_instr); else n_pass++;
         end
         if (i >= 4 && obs_pop) pops++;
      end
      n_checks++;
      if (pops !== 26) $display("FAIL stream_rate got=%0d pops exp=26", pops); else n_pass++;
   endtask

   task automatic test_backpressure();
      int          grants, npop;
      logic [31:0] seen [4];
      grants = 0;
      npop   = 0;
      do_reset();
      for (int i = 0; i < 12; i++) begin
         cycle(1'b1, 1'b0, 1'b0, '0, 1);
         if (obs_grant) grants++;
         n_checks++;
         if (obs_req !== exp_req) $display("FAIL bp_req i=%0d got=%b exp=%b", i, obs_req, exp_req); else n_pass++;
      end
      n_checks++;
      if (grants !== 4) $display("FAIL bp_grants got=%0d exp=4", grants); else n_pass++;
      n_checks++;
      if (obs_req !== 1'b0) $display("FAIL bp_req_stalled got=%b exp=0", obs_req); else n_pass++;
      for (int i = 0; i < 20 && npop < 4; i++) begin
         cycle(1'b0, 1'b1, 1'b0, '0, 1);
         if (obs_pop) begin
            seen[npop] = obs_pc;
            n_checks++;
            if (obs_instr !== mem_word(obs_pc)) $display("FAIL bp_instr got=%h exp=%h", obs_instr, mem_word(obs_pc)); else n_pass++;
            npop++;
         end
      end
      n_checks++;
      if (npop !== 4) $display("FAIL bp_drain_count got=%0d exp=4", npop);
      else begin
         n_pass++;
         for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (seen[k] !== 32'(4 * k)) $display("FAIL bp_order k=%0d got=%h exp=%h", k, seen[k], 32'(4 * k)); else n_pass++;
         end
      end
   endtask

   task automatic test_redirect();
      logic        found;
      logic [31:0] first_pc, first_instr;
      found = 1'b0;
      first_pc = '0;
      first_instr = '0;
      do_reset();
      cycle(1'b1, 1'b0, 1'b0, '0, 0);
      cycle(1'b1, 1'b0, 1'b0, '0, 1);
      cycle(1'b1, 1'b0, 1'b0, '0, 0);
      cycle(1'b0, 1'b0, 1'b1, 32'h100, 0);
      n_checks++;
      if (obs_req !== 1'b0) $display("FAIL redir_req got=%b exp=0", obs_req); else n_pass++;
      for (int i = 0; i < 20 && !found; i++) begin
         cycle(1'b1, 1'b1, 1'b0, '0, 1);
         if (obs_pop) begin
            found = 1'b1;
            first_pc = obs_pc;
            first_instr = obs_instr;
         end
      end
      n_checks++;
      if (!found) $display("FAIL redir_timeout got=no pop exp=pop within 20 cycles"); else n_pass++;
      n_checks++;
      if (first_pc !== 32'h100) $display("FAIL redir_pc got=%h exp=00000100", first_pc); else n_pass++;
      n_checks++;
      if (first_instr !== mem_word(32'h100)) $display("FAIL redir_instr got=%h exp=%h", first_instr, mem_word(32'h100)); else n_pass++;
   endtask

   task automatic test_gnt_stall();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, 1'b1, 1'b0, '0, 1);
         n_checks++;
         if (obs_req !== 1'b1) $display("FAIL stall_req i=%0d got=%b exp=1", i, obs_req); else n_pass++;
         n_checks++;
         if (obs_addr !== RESET_PC) $display("FAIL stall_addr i=%0d got=%h exp=%h", i, obs_addr, RESET_PC); else n_pass++;
      end
      cycle(1'b1, 1'b1, 1'b0, '0, 1);
      n_checks++;
      if (obs_grant !== 1'b1) $display("FAIL stall_grant got=%b exp=1", obs_grant); else n_pass++;
      cycle(1'b1, 1'b1, 1'b0, '0, 1);
      n_checks++;
      if (obs_addr !== RESET_PC + 32'd4) $display("FAIL stall_next_addr got=%h exp=%h", obs_addr, RESET_PC + 32'd4); else n_pass++;
   endtask

   task automatic test_reset_mid();
      logic        found;
      logic [31:0] first_pc;
      found = 1'b0;
      first_pc = '1;
      do_reset();
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, '0, 1);
      @(posedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b1) $display("FAIL midrst_prefill got=%b exp=1", out_valid); else n_pass++;
      #1;
      rst = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL midrst_valid got=%b exp=0", out_valid); else n_pass++;
      n_checks++;
      if (imem_req !== 1'b0) $display("FAIL midrst_req got=%b exp=0", imem_req); else n_pass++;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; out_ready = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_checks++;
      if (imem_req !== 1'b1) $display("FAIL midrst_release_req got=%b exp=1", imem_req); else n_pass++;
      n_checks++;
      if (imem_addr !== RESET_PC) $display("FAIL midrst_release_addr got=%h exp=%h", imem_addr, RESET_PC); else n_pass++;
      for (int i = 0; i < 20 && !found; i++) begin
         cycle(1'b1, 1'b1, 1'b0, '0, 1);
         if (obs_pop) begin
            found = 1'b1;
            first_pc = obs_pc;
         end
      end
      n_checks++;
      if (first_pc !== RESET_PC) $display("FAIL midrst_first_pc got=%h exp=%h", first_pc, RESET_PC); else n_pass++;
   endtask

   task automatic test_redirect_coincident();
      logic        found;
      logic [31:0] first_pc;
      found = 1'b0;
      first_pc = '1;
      do_reset();
      cycle(1'b1, 1'b0, 1'b0, '0, 0);
      cycle(1'b1, 1'b0, 1'b0, '0, 0);
      cycle(1'b1, 1'b0, 1'b0, '0, 1);
      cycle(1'b1, 1'b1, 1'b1, 32'h103, 1);
      n_checks++;
      if (obs_pop !== 1'b1) $display("FAIL coinc_pop got=%b exp=1", obs_pop); else n_pass++;
      n_checks++;
      if (obs_pc !== 32'h0) $display("FAIL coinc_pop_pc got=%h exp=00000000", obs_pc); else n_pass++;
      cycle(1'b1, 1'b1, 1'b0, '0, 1);
      n_checks++;
      if (obs_req !== 1'b1) $display("FAIL coinc_req got=%b exp=1", obs_req); else n_pass++;
      n_checks++;
      if (obs_addr !== 32'h100) $display("FAIL coinc_addr got=%h exp=00000100", obs_addr); else n_pass++;
      for (int i = 0; i < 20 && !found; i++) begin
         cycle(1'b1, 1'b1, 1'b0, '0, 1);
         if (obs_pop) begin
            found = 1'b1;
            first_pc = obs_pc;
         end
      end
      n_checks++;
      if (first_pc !== 32'h100) $display("FAIL coinc_next_pc got=%h exp=00000100", first_pc); else n_pass++;
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         logic        g, r, rd;
         logic [31:0] t;
         g  = ($urandom_range(0, 3) != 0);
         r  = ($urandom_range(0, 2) != 0);
         rd = ($urandom_range(0, 39) == 0);
         t  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
         cycle(g, r, rd, t, 2);
         n_checks++;
         if (obs_req !== exp_req) $display("FAIL rnd_req i=%0d got=%b exp=%b", i, obs_req, exp_req); else n_pass++;
         if (exp_req) begin
            n_checks++;
            if (obs_addr !== exp_addr) $display("FAIL rnd_addr i=%0d got=%h exp=%h", i, obs_addr, exp_addr); else n_pass++;
         end
         n_checks++;
         if (obs_valid !== exp_valid) $display("FAIL rnd_valid i=%0d got=%b exp=%b", i, obs_valid, exp_valid); else n_pass++;
         if (exp_valid) begin
            n_checks++;
            if (obs_pc !== exp_head_pc) $display("FAIL rnd_pc i=%0d got=%h exp=%h", i, obs_pc, exp_head_pc); else n_pass++;
            n_checks++;
            if (obs_instr !== exp_head_instr) $display("FAIL rnd_instr i=%0d got=%h exp=%h", i, obs_instr, exp_head_instr); else n_pass++;
         end
      end
   endtask

   initial begin
      rst = 1'b0;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      out_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
      epoch = 0;
      cyc = 0;
      model_reset();
      test_reset();
      test_stream_lat1();
      test_backpressure();
      test_redirect();
      test_gnt_stall();
      test_reset_mid();
      test_redirect_coincident();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=bench completion");
      $fatal(1, "watchdog expired");
   end

endmodule
